hazard_scoreboard: RTL
======================

HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 SHALL have parameter MAX_PEND, default 3, max outstanding writes per register (counter width 2).
REQ-002 SHALL have parameter STALL_W, default 16, stall-counter width.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-low reset; 0 on a rising clk edge resets.
REQ-005 SHALL have port issue_valid  input  1  ID stage presents an instruction.
REQ-006 SHALL have ports issue_ra, issue_rb  input  5 each  source register indices.
REQ-007 SHALL have ports issue_uses_ra, issue_uses_rb  input  1 each  source actually read.
REQ-008 SHALL have port issue_wr  input  1  instruction writes a destination.
REQ-009 SHALL have port issue_rw  input  5  destination index.
REQ-010 SHALL have port issue_ready  output  1  combinational; issue fires when issue_valid && issue_ready.
REQ-011 SHALL have ports wb_valid  input  1  and wb_rw  input  5  register-file write retiring this cycle (same as RegWr/RW).
REQ-012 SHALL have ports drain_req  input  1  and drain_done  output  1  pipeline-drain handshake.
REQ-013 SHALL have ports pend_any  output  1  (any counter nonzero), wb_err  output  1  (sticky), stall_cnt  output  STALL_W.

Function
REQ-014 SHALL keep pend[r] (0..MAX_PEND) for r=1..31; register 0 is never pending and never stalls.
REQ-015 SHALL flag a RAW hazard on source s when uses_s && s!=0 && pend[s]!=0, unless wb_valid && wb_rw==s && pend[s]==1 (register-file write-through bypass covers it).
REQ-016 SHALL flag a WAW-saturation hazard when issue_wr && issue_rw!=0 && pend[issue_rw]==MAX_PEND, unless wb_valid && wb_rw==issue_rw.
REQ-017 SHALL drive issue_ready = (state==RUN) && no RAW hazard on ra/rb && no WAW-saturation hazard.
REQ-018 SHALL increment pend[issue_rw] on a fire with issue_wr && issue_rw!=0.
REQ-019 SHALL decrement pend[wb_rw] on wb_valid && wb_rw!=0 && pend[wb_rw]!=0.
REQ-020 SHALL leave pend unchanged when fire-increment and retire-decrement hit the same register in one cycle.
REQ-021 SHALL ignore wb_valid to a register with pend 0 and set wb_err (sticky until reset); wb_rw==0 is ignored without error.
REQ-022 SHALL increment stall_cnt each cycle issue_valid && !issue_ready, saturating at all-ones.
REQ-023 SHALL implement FSM RUN, DRAIN, IDLE; RUN->DRAIN when drain_req==1.
REQ-024 SHALL go DRAIN->IDLE when all pend are zero at the start of the cycle; wb retires still decrement in DRAIN.
REQ-025 SHALL assert drain_done, registered, for exactly the first cycle in IDLE.
REQ-026 SHALL go IDLE->RUN when drain_req==0; otherwise remain IDLE.
REQ-027 SHALL hold issue_ready=0 in DRAIN and IDLE regardless of hazards.
REQ-028 SHALL drive pend_any registered-free: combinational OR of current counters.

Reset
REQ-029 SHALL, on reset==0 at a clk edge, clear all pend, stall_cnt=0, wb_err=0, drain_done=0, state=RUN.
REQ-030 SHALL let reset override any simultaneous issue, retire or drain event, including mid-DRAIN.
REQ-031 SHALL yield issue_ready=1 in the first cycle after reset release (no pending state).

Structure
REQ-032 SHALL place FSM state encoding, MAX_PEND, register-index width and STALL_W default in a shared package.
REQ-033 SHALL instantiate one sub-module sb_pend_ctr per register 1..31 (saturating up/down counter, inc/dec/hold, zero and full flags).

Verification
REQ-034 Fire wr r5; next cycle issue reads r5 -> issue_ready=0, stall_cnt=1; wb r5 next cycle -> issue_ready=1 in that same cycle (bypass).
REQ-035 Three fires writing r7, fourth fire writing r7 with no wb -> issue_ready=0; wb r7 same cycle -> ready=1, pend[7] stays 3.
REQ-036 Fire writes r3 with wb_rw=3 same cycle, pend[3]=1 -> pend[3] remains 1; wb r3 next cycle -> pend_any=0.
REQ-037 Issue with ra=0, wr to r0, wb r0 -> no stall, no counter change, wb_err=0; wb r9 with pend 0 -> wb_err=1 sticky.
REQ-038 pend[4]=2, drain_req=1 -> DRAIN, ready=0; two wb r4 -> IDLE next, drain_done pulse 1 cycle; drop drain_req -> RUN.
REQ-039 Mid-DRAIN with pend[6]=1, reset=0 for one edge -> state RUN, pend_any=0, stall_cnt=0, issue_ready=1 after release.

Source files
------------

// File: rtl/hazard_scoreboard_pkg.sv
// rtl/hazard_scoreboard_pkg.sv - shared types, sizes and hazard helper for the hazard scoreboard
//
// Purpose: single home for the register-index width, pending-counter width,
//          default parameters, the drain FSM encoding and the RAW check.
// Ports:   none (package).
package hazard_scoreboard_pkg;

  localparam int REG_W        = 5;
  localparam int NUM_REGS     = 32;
  localparam int CNT_W        = 2;
  localparam int MAX_PEND_DEF = 3;
  localparam int STALL_W_DEF  = 16;

  typedef logic [REG_W-1:0] reg_idx_t;
  typedef logic [CNT_W-1:0] pend_cnt_t;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_IDLE  = 2'd2
  } sb_state_e;

  // A source read is blocked while its register still has writes in
  // flight. The one exception is the last outstanding write retiring in
  // this very cycle: the register file writes through, so the reader
  // already sees the new value.
  function automatic logic raw_hazard(
    input logic      uses,
    input reg_idx_t  src,
    input pend_cnt_t cnt,
    input logic      wb_valid,
    input reg_idx_t  wb_rw
  );
    return uses && (src != '0) && (cnt != '0) &&
           !(wb_valid && (wb_rw == src) && (cnt == pend_cnt_t'(1)));
  endfunction

endpackage

// File: rtl/hazard_scoreboard_if.sv
// rtl/hazard_scoreboard_if.sv - issue and write-back bus between the ID stage and the scoreboard
//
// Purpose: bundles the issue handshake and the register-file retire port.
// Signals: issue_valid/issue_ready  issue handshake (fire = valid && ready)
//          issue_ra/rb, issue_uses_ra/rb  source indices and read enables
//          issue_wr, issue_rw         destination write enable and index
//          wb_valid, wb_rw            register-file write retiring this cycle
// Modports: master = ID stage / pipeline side, slave = scoreboard.
interface hazard_scoreboard_if;
  import hazard_scoreboard_pkg::*;

  logic     issue_valid;
  reg_idx_t issue_ra;
  reg_idx_t issue_rb;
  logic     issue_uses_ra;
  logic     issue_uses_rb;
  logic     issue_wr;
  reg_idx_t issue_rw;
  logic     issue_ready;
  logic     wb_valid;
  reg_idx_t wb_rw;

  modport master (
    output issue_valid, issue_ra, issue_rb, issue_uses_ra, issue_uses_rb,
    output issue_wr, issue_rw, wb_valid, wb_rw,
    input  issue_ready
  );

  modport slave (
    input  issue_valid, issue_ra, issue_rb, issue_uses_ra, issue_uses_rb,
    input  issue_wr, issue_rw, wb_valid, wb_rw,
    output issue_ready
  );

endinterface

// File: rtl/sb_pend_ctr.sv
// rtl/sb_pend_ctr.sv - saturating up/down counter of outstanding writes for one register
//
// Purpose: counts writes issued but not yet retired for a single register.
// Ports:   clk, reset (sync, active-low)
//          inc   a write to this register was issued this cycle
//          dec   a write to this register retired this cycle
//          cnt   current outstanding count (0..MAX)
//          zero  cnt == 0
//          full  cnt == MAX
module sb_pend_ctr
  import hazard_scoreboard_pkg::*;
#(
  parameter int MAX = MAX_PEND_DEF
) (
  input  logic      clk,
  input  logic      reset,
  input  logic      inc,
  input  logic      dec,
  output pend_cnt_t cnt,
  output logic      zero,
  output logic      full
);

  pend_cnt_t cnt_q;
  pend_cnt_t cnt_d;

  assign cnt  = cnt_q;
  assign zero = (cnt_q == '0);
  assign full = (cnt_q == pend_cnt_t'(MAX));

  // Simultaneous inc and dec cancel out; the ends of the range hold so a
  // stray request can never wrap the count.
  always_comb begin
    cnt_d = cnt_q;
    if (inc && !dec && !full) begin
      cnt_d = cnt_q + pend_cnt_t'(1);
    end else if (dec && !inc && !zero) begin
      cnt_d = cnt_q - pend_cnt_t'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// rtl/hazard_scoreboard.sv - register hazard scoreboard with pipeline-drain FSM
//
// Purpose: tracks outstanding writes per register, blocks issue on RAW and
//          WAW-saturation hazards, counts stall cycles and runs a drain
//          handshake that waits for every outstanding write to retire.
// Ports:   clk, reset (sync, active-low)
//          sb          issue / write-back bus (slave modport)
//          drain_req   request to stop issuing and drain the pipeline
//          drain_done  one-cycle registered pulse on entering IDLE
//          pend_any    some register has an outstanding write (combinational)
//          wb_err      sticky: a retire arrived for a register with none pending
//          stall_cnt   saturating count of cycles with issue_valid && !issue_ready
module hazard_scoreboard
  import hazard_scoreboard_pkg::*;
#(
  parameter int MAX_PEND = MAX_PEND_DEF,
  parameter int STALL_W  = STALL_W_DEF
) (
  input  logic                clk,
  input  logic                reset,
  hazard_scoreboard_if.slave  sb,
  input  logic                drain_req,
  output logic                drain_done,
  output logic                pend_any,
  output logic                wb_err,
  output logic [STALL_W-1:0]  stall_cnt
);

  sb_state_e          state_q;
  logic               drain_done_q;
  logic               wb_err_q;
  logic               wb_err_d;
  logic [STALL_W-1:0] stall_q;
  logic [STALL_W-1:0] stall_d;

  pend_cnt_t             pend [NUM_REGS];
  logic [NUM_REGS-1:0]   zero_v;
  logic [NUM_REGS-1:0]   full_v;
  logic [NUM_REGS-1:1]   inc_v;
  logic [NUM_REGS-1:1]   dec_v;

  logic raw_a;
  logic raw_b;
  logic waw_sat;
  logic fire;

  // Register 0 is hardwired: never pending, never full.
  assign pend[0]   = '0;
  assign zero_v[0] = 1'b1;
  assign full_v[0] = 1'b0;

  for (genvar r = 1; r < NUM_REGS; r++) begin : g_ctr
    sb_pend_ctr #(
      .MAX (MAX_PEND)
    ) u_ctr (
      .clk   (clk),
      .reset (reset),
      .inc   (inc_v[r]),
      .dec   (dec_v[r]),
      .cnt   (pend[r]),
      .zero  (zero_v[r]),
      .full  (full_v[r])
    );
  end

  assign raw_a = raw_hazard(sb.issue_uses_ra, sb.issue_ra, pend[sb.issue_ra],
                            sb.wb_valid, sb.wb_rw);
  assign raw_b = raw_hazard(sb.issue_uses_rb, sb.issue_rb, pend[sb.issue_rb],
                            sb.wb_valid, sb.wb_rw);

  // A saturated destination frees a slot if one of its writes retires now.
  assign waw_sat = sb.issue_wr && (sb.issue_rw != '0) && full_v[sb.issue_rw] &&
                   !(sb.wb_valid && (sb.wb_rw == sb.issue_rw));

  assign sb.issue_ready = (state_q == ST_RUN) && !raw_a && !raw_b && !waw_sat;
  assign fire           = sb.issue_valid && sb.issue_ready;

  assign pend_any   = ~&zero_v;
  assign drain_done = drain_done_q;
  assign wb_err     = wb_err_q;
  assign stall_cnt  = stall_q;

  // Retires only decrement a register that actually has a write in flight;
  // the counter itself resolves a same-cycle issue and retire to "hold".
  always_comb begin
    inc_v = '0;
    dec_v = '0;
    for (int r = 1; r < NUM_REGS; r++) begin
      inc_v[r] = fire && sb.issue_wr && (sb.issue_rw == reg_idx_t'(r));
      dec_v[r] = sb.wb_valid && (sb.wb_rw == reg_idx_t'(r)) && !zero_v[r];
    end
  end

  always_comb begin
    wb_err_d = wb_err_q;
    if (sb.wb_valid && (sb.wb_rw != '0) && zero_v[sb.wb_rw]) begin
      wb_err_d = 1'b1;
    end
  end

  always_comb begin
    stall_d = stall_q;
    if (sb.issue_valid && !sb.issue_ready && (stall_q != '1)) begin
      stall_d = stall_q + STALL_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wb_err_q <= 1'b0;
      stall_q  <= '0;
    end else begin
      wb_err_q <= wb_err_d;
      stall_q  <= stall_d;
    end
  end

  // Drain FSM. DRAIN leaves on the counters seen at the start of the cycle,
  // so the final retire is absorbed one cycle before IDLE. drain_done is
  // raised on the transition into IDLE and dropped on the following edge.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= ST_RUN;
      drain_done_q <= 1'b0;
    end else begin
      drain_done_q <= 1'b0;
      case (state_q)
        ST_RUN: begin
          if (drain_req) begin
            state_q <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (!pend_any) begin
            state_q      <= ST_IDLE;
            drain_done_q <= 1'b1;
          end
        end
        ST_IDLE: begin
          if (!drain_req) begin
            state_q <= ST_RUN;
          end
        end
        default: begin
          state_q <= ST_RUN;
        end
      endcase
    end
  end

endmodule
